// File: rtl/cc_address_decoder.sv
// cc_address_decoder: Crystal Castles CPU address decoder with chip selects and 1-clk write strobes
//
// Ports:
//   clk, reset_n          10 MHz system clock, asynchronous active-low reset
//   ce2H, ce2Hd           bus-cycle start enable / delayed data-valid enable
//   BA[15:0], BRWn        CPU address and read(1)/write(0)
//   NRn                   active-high ROM space flag (0xA000-0xFFFF)
//   ROM0n..ROM2n, SRAMn, SBUSn, NVRAMn, IN0n, CIOn, UARTn, BITMDn
//                         combinational active-low selects, follow BA at all times
//   HSLDn, VSLDn, INTACKn, WDOGn, OUT0n, OUT1n, CRAMn, XCOORDn, YCOORDn
//                         registered active-low write strobes, one clk wide
//
// Build option: define CC_UART_DECODE_EN to decode UARTn at 0x9C00-0x9C7F;
// otherwise UARTn is tied high and that window decodes to nothing.
module cc_address_decoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce2H,
    input  logic        ce2Hd,
    input  logic [15:0] BA,
    input  logic        BRWn,
    output logic        NRn,
    output logic        ROM0n,
    output logic        ROM1n,
    output logic        ROM2n,
    output logic        SRAMn,
    output logic        SBUSn,
    output logic        NVRAMn,
    output logic        IN0n,
    output logic        CIOn,
    output logic        UARTn,
    output logic        HSLDn,
    output logic        VSLDn,
    output logic        INTACKn,
    output logic        WDOGn,
    output logic        OUT0n,
    output logic        OUT1n,
    output logic        CRAMn,
    output logic        XCOORDn,
    output logic        YCOORDn,
    output logic        BITMDn
);
    logic       w_ctrl;
    logic [8:0] w_strb_dec;
    logic [8:0] r_strb_n;
    logic       r_armed;
    logic       r_pend;

    assign NRn    = BA[15] & (BA[14] | BA[13]);
    assign ROM0n  = BA[15:13] != 3'b101;
    assign ROM1n  = BA[15:13] != 3'b110;
    assign ROM2n  = BA[15:13] != 3'b111;
    assign SRAMn  = BA[15:12] != 4'h8;
    assign SBUSn  = BA[15:9]  != 7'b1000111;
    assign NVRAMn = BA[15:10] != 6'b100100;
    assign IN0n   = BA[15:10] != 6'b100101;
    assign CIOn   = BA[15:10] != 6'b100110;
    assign BITMDn = BA != 16'h0002;
`ifdef CC_UART_DECODE_EN
    assign UARTn  = BA[15:7] != 9'b1001_1100_0;
`else
    assign UARTn  = 1'b1;
`endif

    // 0x9C00-0x9FFF splits into eight 128-byte slots; slot 0 is the UART, 1..7 are strobes
    assign w_ctrl     = BA[15:10] == 6'b100111;
    assign w_strb_dec = {w_ctrl && BA[9:7] == 3'd1, w_ctrl && BA[9:7] == 3'd2,
                         w_ctrl && BA[9:7] == 3'd3, w_ctrl && BA[9:7] == 3'd4,
                         w_ctrl && BA[9:7] == 3'd5, w_ctrl && BA[9:7] == 3'd6,
                         w_ctrl && BA[9:7] == 3'd7, BA == 16'h0000, BA == 16'h0001};

    assign {HSLDn, VSLDn, INTACKn, WDOGn, OUT0n, OUT1n, CRAMn, XCOORDn, YCOORDn} = r_strb_n;

    // r_armed: a ce2H has been seen and its ce2Hd is awaited; r_pend: that cycle is a write.
    // Strobes default high each clk, so any fired strobe lasts exactly one clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed  <= 1'b0;
            r_pend   <= 1'b0;
            r_strb_n <= '1;
        end else begin
            r_strb_n <= (r_armed && ce2Hd && r_pend) ? ~w_strb_dec : '1;
            r_armed  <= ce2H || (r_armed && !ce2Hd);
            r_pend   <= ce2H ? ~BRWn : r_pend;
        end
    end
endmodule

// File: tb/tb_cc_address_decoder.sv
// tb_cc_address_decoder: self-checking bench for cc_address_decoder against a range-based model
module tb_cc_address_decoder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce2H = 1'b0;
    logic        ce2Hd = 1'b0;
    logic        BRWn = 1'b1;
    logic [15:0] BA = 16'h0000;
    logic NRn, ROM0n, ROM1n, ROM2n, SRAMn, SBUSn, NVRAMn, IN0n, CIOn, UARTn;
    logic HSLDn, VSLDn, INTACKn, WDOGn, OUT0n, OUT1n, CRAMn, XCOORDn, YCOORDn, BITMDn;
    logic [10:0] sel;
    logic [8:0]  strb;
    int checks = 0;
    int errors = 0;
    localparam logic [8:0] ALL = 9'h1FF;

    always #5 clk = ~clk;

    cc_address_decoder dut (
        .clk(clk), .reset_n(reset_n), .ce2H(ce2H), .ce2Hd(ce2Hd), .BA(BA), .BRWn(BRWn),
        .NRn(NRn), .ROM0n(ROM0n), .ROM1n(ROM1n), .ROM2n(ROM2n), .SRAMn(SRAMn), .SBUSn(SBUSn),
        .NVRAMn(NVRAMn), .IN0n(IN0n), .CIOn(CIOn), .UARTn(UARTn), .HSLDn(HSLDn), .VSLDn(VSLDn),
        .INTACKn(INTACKn), .WDOGn(WDOGn), .OUT0n(OUT0n), .OUT1n(OUT1n), .CRAMn(CRAMn),
        .XCOORDn(XCOORDn), .YCOORDn(YCOORDn), .BITMDn(BITMDn)
    );

    assign sel  = {NRn, ROM0n, ROM1n, ROM2n, SRAMn, SBUSn, NVRAMn, IN0n, CIOn, UARTn, BITMDn};
    assign strb = {HSLDn, VSLDn, INTACKn, WDOGn, OUT0n, OUT1n, CRAMn, XCOORDn, YCOORDn};

    function automatic logic in_rng(input int a, input int lo, input int hi);
        return a >= lo && a <= hi;
    endfunction

    function automatic logic [10:0] exp_sel(input int a);
        logic uart;
`ifdef CC_UART_DECODE_EN
        uart = !in_rng(a, 'h9C00, 'h9C7F);
`else
        uart = 1'b1;
`endif
        return {in_rng(a, 'hA000, 'hFFFF), !in_rng(a, 'hA000, 'hBFFF), !in_rng(a, 'hC000, 'hDFFF),
                !in_rng(a, 'hE000, 'hFFFF), !in_rng(a, 'h8000, 'h8FFF), !in_rng(a, 'h8E00, 'h8FFF),
                !in_rng(a, 'h9000, 'h93FF), !in_rng(a, 'h9400, 'h97FF), !in_rng(a, 'h9800, 'h9BFF),
                uart, a != 2};
    endfunction

    // Strobe regions in output order: HSLD, VSLD, INTACK, WDOG, OUT0, OUT1, CRAM
    function automatic logic [8:0] exp_strb(input int a);
        logic [8:0] e;
        e = ALL;
        for (int k = 0; k < 7; k++)
            if (in_rng(a, 'h9C80 + k * 'h80, 'h9CFF + k * 'h80)) e[8 - k] = 1'b0;
        if (a == 0) e[1] = 1'b0;
        if (a == 1) e[0] = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] a, input logic rw, input int gap, input logic rst_mid);
        BA = a;
        BRWn = rw;
        ce2H = 1'b1;
        @(posedge clk);
        #1 ce2H = 1'b0;
        chk("strb_after_ce2H", {7'd0, strb}, {7'd0, ALL});
        if (rst_mid) begin
            reset_n = 1'b0;
            #2 chk("strb_in_reset", {7'd0, strb}, {7'd0, ALL});
            chk("sel_in_reset", {5'd0, sel}, {5'd0, exp_sel(int'(a))});
            #2 reset_n = 1'b1;
        end
        for (int i = 1; i < gap; i++) begin
            @(posedge clk);
            #1 chk("strb_wait", {7'd0, strb}, {7'd0, ALL});
        end
        ce2Hd = 1'b1;
        @(posedge clk);
        #1 ce2Hd = 1'b0;
        chk("strb_pulse", {7'd0, strb}, {7'd0, (rw || rst_mid) ? ALL : exp_strb(int'(a))});
        chk("sel_cycle", {5'd0, sel}, {5'd0, exp_sel(int'(a))});
        @(posedge clk);
        #1 chk("strb_release", {7'd0, strb}, {7'd0, ALL});
    endtask

    initial begin
        logic [15:0] a;
        repeat (3) @(posedge clk);
        #1 chk("reset_strb", {7'd0, strb}, {7'd0, ALL});
        chk("reset_sel", {5'd0, sel}, {5'd0, exp_sel(0)});
        reset_n = 1'b1;
        for (int x = 0; x < 65536; x++) begin
            BA = x[15:0];
            #1 chk("sel_sweep", {5'd0, sel}, {5'd0, exp_sel(x)});
            chk("strb_sweep", {7'd0, strb}, {7'd0, ALL});
        end
        BA = 16'hA123;
        #1 chk("a123_nr_rom0", {14'd0, NRn, ROM0n}, 16'h0002);
        BA = 16'h8E10;
        #1 chk("8e10_sram_sbus", {14'd0, SRAMn, SBUSn}, 16'h0000);
        @(posedge clk);
        #1;
        cyc(16'h9C80, 1'b0, 2, 1'b0);
        cyc(16'h9E80, 1'b0, 2, 1'b0);
        cyc(16'h9F03, 1'b0, 3, 1'b0);
        cyc(16'h9FA0, 1'b0, 1, 1'b0);
        cyc(16'h0000, 1'b0, 4, 1'b0);
        cyc(16'h0001, 1'b0, 2, 1'b0);
        cyc(16'h0100, 1'b0, 2, 1'b0);
        cyc(16'h8000, 1'b0, 2, 1'b0);
        cyc(16'h9E00, 1'b1, 2, 1'b0);
        cyc(16'h9E00, 1'b0, 2, 1'b0);
        cyc(16'h9D00, 1'b0, 2, 1'b1);
        cyc(16'h9C01, 1'b0, 2, 1'b0);
        cyc(16'h9C01, 1'b1, 2, 1'b0);
        repeat (400) begin
            case ($urandom_range(0, 3))
                0: a = 16'($urandom);
                1: a = 16'('h9C00 + $urandom_range(0, 'h3FF));
                2: a = 16'($urandom_range(0, 3));
                default: a = 16'('h9C80 + $urandom_range(0, 'h37F));
            endcase
            cyc(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), $urandom_range(0, 15) == 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1 chk("strb_idle", {7'd0, strb}, {7'd0, ALL});
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
